// File: rtl/bpred_resolve_pkg.sv
// Shared scalar-core parameters for the branch predictor: PC width and the
// PC-to-table-index slice used by both the predictor table and the resolver.
package bpred_resolve_pkg;

    localparam int CORE_PCWIDTH   = 32;
    localparam int LOG2TABLEDEPTH = 8;
    localparam int IDX_LSB        = 2;
    localparam int IDX_MSB        = LOG2TABLEDEPTH + 1;

    // Table index of a branch: word-aligned PC bits above the byte offset.
    function automatic logic [LOG2TABLEDEPTH-1:0] pc_index(input logic [CORE_PCWIDTH-1:0] pc);
        return pc[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/bpred_fifo.sv
// In-order synchronous FIFO of in-flight branches; clear empties it in the
// same edge and overrides any push or pop presented with it.
module bpred_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    input  logic                 clear,
    output logic [WIDTH-1:0]     head_data,
    output logic [LOG2DEPTH:0]   count
);

    localparam logic [LOG2DEPTH:0] FULL_COUNT = (LOG2DEPTH+1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG2DEPTH-1:0] wr_ptr;
    logic [LOG2DEPTH-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign push_ok   = push && (count != FULL_COUNT) && !clear;
    assign pop_ok    = pop && (count != '0) && !clear;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bpred_resolve.sv
// Tracks in-flight branch predictions and, as each one resolves, emits the
// predictor-table update and a one-cycle mispredict pulse.
module bpred_resolve
    import bpred_resolve_pkg::*;
#(
    parameter int PCWIDTH       = CORE_PCWIDTH,
    parameter int DEPTH         = 4,
    parameter int LOG2DEPTH     = 2,
    parameter int UPDATE_ALWAYS = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pred_valid,
    input  logic [PCWIDTH-1:0]   pred_pc,
    input  logic                 pred_taken,
    output logic                 pred_ready,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    input  logic                 flush,
    output logic                 result_rdy,
    output logic                 result,
    output logic [PCWIDTH-1:0]   pc_result,
    output logic                 mispredict,
    output logic [PCWIDTH-1:0]   mispredict_pc,
    output logic [LOG2DEPTH:0]   occupancy,
    output logic                 err_underflow
);

    localparam logic [LOG2DEPTH:0] FULL_COUNT = (LOG2DEPTH+1)'(DEPTH);

    // Handshake: a prediction is accepted on an edge where pred_valid and
    // pred_ready are both high; pred_ready depends only on registered occupancy,
    // so a pop in the same cycle never admits an extra push.
    logic               do_pop;
    logic               mis_now;
    logic               clear;
    logic               do_push;
    logic [PCWIDTH:0]   head_data;
    logic [PCWIDTH-1:0] head_pc;
    logic               head_taken;

    assign head_pc    = head_data[PCWIDTH:1];
    assign head_taken = head_data[0];

    assign pred_ready = (occupancy != FULL_COUNT);
    assign do_pop     = resolve_valid && (occupancy != '0);
    assign mis_now    = do_pop && (head_taken != resolve_taken);
    // Younger entries were fetched down the wrong path once the head mispredicts.
    assign clear      = flush || mis_now;
    assign do_push    = pred_valid && pred_ready && !clear;

    bpred_fifo #(
        .WIDTH     (PCWIDTH + 1),
        .DEPTH     (DEPTH),
        .LOG2DEPTH (LOG2DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (do_push),
        .push_data ({pred_pc, pred_taken}),
        .pop       (do_pop),
        .clear     (clear),
        .head_data (head_data),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            result_rdy    <= 1'b0;
            result        <= 1'b0;
            pc_result     <= '0;
            mispredict    <= 1'b0;
            mispredict_pc <= '0;
            err_underflow <= 1'b0;
        end else begin
            result_rdy <= do_pop && ((UPDATE_ALWAYS != 0) || mis_now);
            mispredict <= mis_now;
            if (do_pop) begin
                result        <= resolve_taken;
                pc_result     <= head_pc;
                mispredict_pc <= head_pc;
            end
            if (resolve_valid && (occupancy == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bpred_resolve.sv
// Self-checking bench for bpred_resolve: a reference queue model predicts each
// cycle's outputs; scenario tasks add targeted checks on top of it.
module tb_bpred_resolve;

    localparam int PCW   = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
    } entry_t;

    logic           clk;
    logic           resetn;
    logic           pred_valid;
    logic [PCW-1:0] pred_pc;
    logic           pred_taken;
    logic           resolve_valid;
    logic           resolve_taken;
    logic           flush;

    logic           pred_ready,    b_pred_ready;
    logic           result_rdy,    b_result_rdy;
    logic           result,        b_result;
    logic [PCW-1:0] pc_result,     b_pc_result;
    logic           mispredict,    b_mispredict;
    logic [PCW-1:0] mispredict_pc, b_mispredict_pc;
    logic [2:0]     occupancy,     b_occupancy;
    logic           err_underflow, b_err_underflow;

    int total = 0;
    int bad   = 0;

    entry_t     mq[$];
    logic       err_m;
    logic [35:0] exp_q[$];

    bpred_resolve #(.PCWIDTH(PCW), .DEPTH(DEPTH), .LOG2DEPTH(2), .UPDATE_ALWAYS(1)) u_dut (
        .clk(clk), .resetn(resetn), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_ready(pred_ready), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .flush(flush), .result_rdy(result_rdy),
        .result(result), .pc_result(pc_result), .mispredict(mispredict),
        .mispredict_pc(mispredict_pc), .occupancy(occupancy), .err_underflow(err_underflow)
    );

    bpred_resolve #(.PCWIDTH(PCW), .DEPTH(DEPTH), .LOG2DEPTH(2), .UPDATE_ALWAYS(0)) u_dut_b (
        .clk(clk), .resetn(resetn), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_ready(b_pred_ready), .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken), .flush(flush), .result_rdy(b_result_rdy),
        .result(b_result), .pc_result(b_pc_result), .mispredict(b_mispredict),
        .mispredict_pc(b_mispredict_pc), .occupancy(b_occupancy), .err_underflow(b_err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the negedge, predict outputs with the model, push the
    // expectation, then pop and compare it at the following negedge.
    task automatic drive_cycle(input logic pv, input logic [PCW-1:0] pc, input logic pt,
                               input logic rv, input logic rt, input logic fl);
        entry_t         h;
        logic           pready;
        logic           rdy, rdy_b, mis, res;
        logic [PCW-1:0] epc;
        logic [35:0]    e;
        logic [2:0]     exp_occ;
        rdy = 1'b0; rdy_b = 1'b0; mis = 1'b0; res = 1'b0; epc = '0;
        pred_valid = pv; pred_pc = pc; pred_taken = pt;
        resolve_valid = rv; resolve_taken = rt; flush = fl;
        if (!resetn) begin
            mq.delete();
            err_m = 1'b0;
        end else begin
            pready = (mq.size() != DEPTH);
            if (rv) begin
                if (mq.size() == 0) begin
                    err_m = 1'b1;
                end else begin
                    h     = mq.pop_front();
                    mis   = (h.taken != rt);
                    rdy   = 1'b1;
                    rdy_b = mis;
                    res   = rt;
                    epc   = h.pc;
                    if (mis) mq.delete();
                end
            end
            if (fl) mq.delete();
            if (pv && pready && !fl && !mis) mq.push_back('{pc: pc, taken: pt});
        end
        exp_q.push_back({rdy, rdy_b, mis, res, epc});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        exp_occ = 3'(mq.size());
        total++;
        if (result_rdy !== e[35]) begin
            bad++; $display("FAIL sb_result_rdy: got %0b want %0b at %0t", result_rdy, e[35], $time);
        end
        total++;
        if (b_result_rdy !== e[34]) begin
            bad++; $display("FAIL sb_result_rdy_b: got %0b want %0b at %0t", b_result_rdy, e[34], $time);
        end
        total++;
        if (mispredict !== e[33]) begin
            bad++; $display("FAIL sb_mispredict: got %0b want %0b at %0t", mispredict, e[33], $time);
        end
        if (e[35]) begin
            total++;
            if (result !== e[32] || pc_result !== e[31:0]) begin
                bad++; $display("FAIL sb_update: got %0b/%h want %0b/%h", result, pc_result, e[32], e[31:0]);
            end
        end
        if (e[33]) begin
            total++;
            if (mispredict_pc !== e[31:0]) begin
                bad++; $display("FAIL sb_mispredict_pc: got %h want %h", mispredict_pc, e[31:0]);
            end
        end
        total++;
        if (occupancy !== exp_occ || b_occupancy !== exp_occ) begin
            bad++; $display("FAIL sb_occupancy: got %0d/%0d want %0d", occupancy, b_occupancy, exp_occ);
        end
        total++;
        if (pred_ready !== (exp_occ != 3'(DEPTH))) begin
            bad++; $display("FAIL sb_pred_ready: got %0b want %0b", pred_ready, exp_occ != 3'(DEPTH));
        end
        total++;
        if (err_underflow !== err_m) begin
            bad++; $display("FAIL sb_err_underflow: got %0b want %0b", err_underflow, err_m);
        end
        pred_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive_cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if ({result_rdy, result, pc_result, mispredict, mispredict_pc, occupancy, err_underflow} !== '0) begin
            bad++; $display("FAIL reset_outputs: rdy=%0b res=%0b pc=%h mis=%0b mpc=%h occ=%0d err=%0b",
                            result_rdy, result, pc_result, mispredict, mispredict_pc, occupancy, err_underflow);
        end
        resetn = 1'b1;
        total++;
        if (pred_ready !== 1'b1) begin
            bad++; $display("FAIL reset_pred_ready: got %0b want 1", pred_ready);
        end
    endtask

    task automatic test_correct();
        drive_cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (result_rdy !== 1'b1 || result !== 1'b1 || pc_result !== 32'h100 || mispredict !== 1'b0) begin
            bad++; $display("FAIL correct_update: rdy=%0b res=%0b pc=%h mis=%0b want 1/1/100/0",
                            result_rdy, result, pc_result, mispredict);
        end
        idle();
        total++;
        if (result_rdy !== 1'b0 || pc_result !== 32'h100) begin
            bad++; $display("FAIL correct_hold: rdy=%0b pc=%h want 0/100", result_rdy, pc_result);
        end
    endtask

    task automatic test_mispredict();
        drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (mispredict !== 1'b1 || mispredict_pc !== 32'h200 || occupancy !== 3'd0) begin
            bad++; $display("FAIL mispredict_flush: mis=%0b mpc=%h occ=%0d want 1/200/0",
                            mispredict, mispredict_pc, occupancy);
        end
        idle();
        total++;
        if (mispredict !== 1'b0) begin
            bad++; $display("FAIL mispredict_pulse_width: got %0b want 0", mispredict);
        end
    endtask

    task automatic test_full();
        logic [PCW-1:0] pcs[4];
        pcs[0] = 32'h300; pcs[1] = 32'h304; pcs[2] = 32'h308; pcs[3] = 32'h30c;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, pcs[i], i[0], 1'b0, 1'b0, 1'b0);
        total++;
        if (pred_ready !== 1'b0 || occupancy !== 3'd4) begin
            bad++; $display("FAIL full_state: ready=%0b occ=%0d want 0/4", pred_ready, occupancy);
        end
        drive_cycle(1'b1, 32'h310, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b1, i[0], 1'b0);
            total++;
            if (pc_result !== pcs[i] || result_rdy !== 1'b1) begin
                bad++; $display("FAIL full_order%0d: pc=%h rdy=%0b want %h/1", i, pc_result, result_rdy, pcs[i]);
            end
        end
        total++;
        if (occupancy !== 3'd0) begin
            bad++; $display("FAIL full_drained: occ=%0d want 0", occupancy);
        end
    endtask

    task automatic test_update_mode();
        drive_cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (b_result_rdy !== 1'b0) begin
            bad++; $display("FAIL mode0_correct: rdy=%0b want 0", b_result_rdy);
        end
        drive_cycle(1'b1, 32'h404, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (b_result_rdy !== 1'b1 || b_pc_result !== 32'h404 || b_result !== 1'b0) begin
            bad++; $display("FAIL mode0_wrong: rdy=%0b pc=%h res=%0b want 1/404/0", b_result_rdy, b_pc_result, b_result);
        end
    endtask

    task automatic test_reset_midop();
        drive_cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        resetn = 1'b1;
        total++;
        if (result_rdy !== 1'b0 || mispredict !== 1'b0 || occupancy !== 3'd0) begin
            bad++; $display("FAIL reset_midop: rdy=%0b mis=%0b occ=%0d want 0/0/0", result_rdy, mispredict, occupancy);
        end
    endtask

    task automatic test_underflow();
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (err_underflow !== 1'b1 || result_rdy !== 1'b0) begin
            bad++; $display("FAIL underflow_set: err=%0b rdy=%0b want 1/0", err_underflow, result_rdy);
        end
        drive_cycle(1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        total++;
        if (err_underflow !== 1'b1 || occupancy !== 3'd1) begin
            bad++; $display("FAIL underflow_sticky: err=%0b occ=%0d want 1/1", err_underflow, occupancy);
        end
        resetn = 1'b0;
        idle();
        resetn = 1'b1;
        total++;
        if (err_underflow !== 1'b0) begin
            bad++; $display("FAIL underflow_reset: err=%0b want 0", err_underflow);
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h708, 1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if (result_rdy !== 1'b1 || pc_result !== 32'h700 || occupancy !== 3'd0) begin
            bad++; $display("FAIL flush_resolve: rdy=%0b pc=%h occ=%0d want 1/700/0", result_rdy, pc_result, occupancy);
        end
        idle();
        total++;
        if (result_rdy !== 1'b0 || occupancy !== 3'd0) begin
            bad++; $display("FAIL flush_after: rdy=%0b occ=%0d want 0/0", result_rdy, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h804, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (occupancy !== 3'd1 || pc_result !== 32'h800) begin
            bad++; $display("FAIL b2b_pushpop: occ=%0d pc=%h want 1/800", occupancy, pc_result);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive_cycle($urandom_range(0, 99) < 60, {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                        1'($urandom_range(0, 1)), $urandom_range(0, 99) < 45,
                        1'($urandom_range(0, 1)), $urandom_range(0, 99) < 4);
        end
    endtask

    initial begin
        resetn = 1'b0; err_m = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
        @(negedge clk);
        test_reset();
        test_correct();
        test_mispredict();
        test_full();
        test_update_mode();
        test_reset_midop();
        test_underflow();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
